seq_div_8by4: RTL and testbench

Sequential restoring divider, the inverse of the 4x4 -> 8 multiplier. Divides an N-bit unsigned dividend by an M-bit unsigned divisor. Produces an N-bit quotient and an M-bit remainder, one quotient bit per clock. Uses a start/busy/done handshake and sits beside the adder/multiplier blocks in the arithmetic unit.

---
 rtl/seq_div_8by4_if.sv | 46 ++++
 rtl/seq_div_8by4.sv | 148 ++++++++++++++
 tb/tb_seq_div_8by4.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_div_8by4_if.sv
// -----------------------------------------------------------------------------
// seq_div_8by4_if
// Bundles the request/result signals of the sequential divider.
//
// Handshake: the requester raises start together with dividend/divisor. The
// request is taken on a rising clock edge only while busy=0. It is ignored
// while busy=1. The result (quotient, remainder, dz) is valid while done=1.
// The result holds until the next accepted start.
//
// Signals:
//   start      requester -> divider  operation request
//   dividend   requester -> divider  N-bit unsigned dividend
//   divisor    requester -> divider  M-bit unsigned divisor
//   busy       divider -> requester  iteration in progress
//   done       divider -> requester  result valid
//   quotient   divider -> requester  N-bit quotient
//   remainder  divider -> requester  M-bit remainder
//   dz         divider -> requester  divide-by-zero flag, valid with done
//
// Modports:
//   master  the requester side
//   slave   the divider side
// -----------------------------------------------------------------------------
interface seq_div_8by4_if #(
   parameter int N = 8,
   parameter int M = 4
) ();
   logic         start;
   logic [N-1:0] dividend;
   logic [M-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [M-1:0] remainder;
   logic         dz;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, dz
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, dz
   );
endinterface

// File: rtl/seq_div_8by4.sv
// -----------------------------------------------------------------------------
// seq_div_8by4
// Sequential restoring divider. It divides an N-bit unsigned dividend by an
// M-bit unsigned divisor and produces one quotient bit per clock. A normal
// operation takes N cycles from the accepting edge to done.
//
// Optional build macro: DIV_ZERO_DET_EN
//   When the macro is defined, a zero divisor is detected at accept. The block
//   then finishes after one cycle with dz=1. When the macro is undefined, a
//   zero divisor runs all N steps and dz is tied to 0.
//   In both builds a zero divisor gives quotient = all ones and
//   remainder = dividend[M-1:0].
//
// Ports:
//   clk        rising-edge clock
//   rst_b      asynchronous active-low reset
//   bus        seq_div_8by4_if.slave (start/operands in, status/results out)
//   dbg_state  current FSM state (IDLE=0, RUN=1, DONE=2), for observation
// -----------------------------------------------------------------------------
module seq_div_8by4 #(
   parameter int N = 8,
   parameter int M = 4
) (
   input  logic                clk,
   input  logic                rst_b,
   seq_div_8by4_if.slave       bus,
   output logic [1:0]          dbg_state
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state, state_nxt;

   logic [N-1:0]  q_reg;      // dividend shifting out, quotient shifting in
   logic [M-1:0]  d_reg;      // captured divisor
   logic [M-1:0]  r_reg;      // partial remainder
   logic [CW-1:0] cnt;        // steps completed in the current operation
   logic [N-1:0]  quo_reg;    // visible result, updated only on entry to DONE
   logic [M-1:0]  rem_reg;

   logic          accept;
   logic          last_step;
   logic          zero_path;  // current RUN cycle is the one-cycle zero-divisor exit

   logic [M:0]    t;
   logic          ge;
   logic [M-1:0]  r_step;
   logic [N-1:0]  q_step;

   // A start is taken in any state except RUN.
   assign accept    = bus.start && (state != RUN);
   assign last_step = (cnt == CW'(N - 1));

   // One restoring step. T is compared against the zero-extended divisor. When
   // the subtraction is taken, T >= D, so the low M bits of T-D equal the full
   // difference truncated to M bits.
   always_comb begin
      t      = {r_reg, q_reg[N-1]};
      ge     = (t >= {1'b0, d_reg});
      r_step = ge ? (t[M-1:0] - d_reg) : t[M-1:0];
      q_step = {q_reg[N-2:0], ge};
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (zero_path || last_step) state_nxt = DONE;
         DONE:    if (accept) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         q_reg   <= '0;
         d_reg   <= '0;
         r_reg   <= '0;
         cnt     <= '0;
         quo_reg <= '0;
         rem_reg <= '0;
      end else if (accept) begin
         q_reg <= bus.dividend;
         d_reg <= bus.divisor;
         r_reg <= '0;
         cnt   <= '0;
      end else if (state == RUN) begin
         if (zero_path) begin
            // q_reg still holds the untouched dividend here.
            quo_reg <= '1;
            rem_reg <= q_reg[M-1:0];
         end else begin
            q_reg <= q_step;
            r_reg <= r_step;
            cnt   <= cnt + 1'b1;
            if (last_step) begin
               quo_reg <= q_step;
               rem_reg <= r_step;
            end
         end
      end
   end

`ifdef DIV_ZERO_DET_EN
   logic dz_pend;  // divisor captured at accept was zero
   logic dz_reg;

   assign zero_path = (state == RUN) && dz_pend;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         dz_pend <= 1'b0;
         dz_reg  <= 1'b0;
      end else if (accept) begin
         dz_pend <= (bus.divisor == '0);
         dz_reg  <= 1'b0;
      end else if (zero_path) begin
         dz_reg  <= 1'b1;
      end
   end

   assign bus.dz = dz_reg;
`else
   assign zero_path = 1'b0;
   assign bus.dz    = 1'b0;
`endif

   assign bus.busy      = (state == RUN);
   assign bus.done      = (state == DONE);
   assign bus.quotient  = quo_reg;
   assign bus.remainder = rem_reg;
   assign dbg_state     = state;

endmodule

// File: tb/tb_seq_div_8by4.sv
// -----------------------------------------------------------------------------
// tb_seq_div_8by4
// Self-checking bench for seq_div_8by4. The reference model uses integer / and
// % on the operands. A zero divisor gives quotient = all ones and
// remainder = dividend[M-1:0].
// -----------------------------------------------------------------------------
module tb_seq_div_8by4;

   localparam int N = 8;
   localparam int M = 4;

`ifdef DIV_ZERO_DET_EN
   localparam int ZERO_LAT = 1;
   localparam logic ZERO_DZ = 1'b1;
`else
   localparam int ZERO_LAT = N;
   localparam logic ZERO_DZ = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_b = 1'b0;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   seq_div_8by4_if #(.N(N), .M(M)) bus ();

   seq_div_8by4 #(.N(N), .M(M)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fails  = 0;
   logic [N+M-1:0] exp_q[$];

   // Reference model
   task automatic ref_div(input logic [N-1:0] a, input logic [M-1:0] b,
                          output logic [N-1:0] q, output logic [M-1:0] r);
      if (b == '0) begin
         q = '1;
         r = a[M-1:0];
      end else begin
         q = N'(int'(a) / int'(b));
         r = M'(int'(a) % int'(b));
      end
   endtask

   // ---------------- driver tasks ----------------
   // All tasks start and end at 1 time unit after a rising edge.
   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_op(input logic [N-1:0] a, input logic [M-1:0] b);
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
   endtask

   // Returns the number of edges until done, or -1 if max elapses first.
   task automatic wait_done(input int max, output int cycles);
      cycles = 0;
      while (bus.done !== 1'b1 && cycles < max) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      if (bus.done !== 1'b1) cycles = -1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      rst_b        = 1'b0;
      idle_cycles(3);
      n_checks++;
      if ({bus.busy, bus.done, bus.dz, bus.quotient, bus.remainder} !== '0) begin
         n_fails++;
         $display("FAIL reset_in: busy=%b done=%b dz=%b q=%0d r=%0d, want all 0",
                  bus.busy, bus.done, bus.dz, bus.quotient, bus.remainder);
      end
      rst_b = 1'b1;
      idle_cycles(2);
      n_checks++;
      if ({bus.busy, bus.done, bus.dz, bus.quotient, bus.remainder} !== '0) begin
         n_fails++;
         $display("FAIL reset_after: busy=%b done=%b dz=%b q=%0d r=%0d, want all 0",
                  bus.busy, bus.done, bus.dz, bus.quotient, bus.remainder);
      end
   endtask

   task automatic test_basic();
      logic [N-1:0] eq;
      logic [M-1:0] er;
      ref_div(8'd200, 4'd7, eq, er);
      drive_op(8'd200, 4'd7);
      for (int k = 1; k <= N; k++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (k < N) begin
            if ({bus.busy, bus.done} !== 2'b10) begin
               n_fails++;
               $display("FAIL basic_run_c%0d: busy/done=%b, want 10", k, {bus.busy, bus.done});
            end
         end else if ({bus.busy, bus.done} !== 2'b01) begin
            n_fails++;
            $display("FAIL basic_done_c%0d: busy/done=%b, want 01", k, {bus.busy, bus.done});
         end
      end
      n_checks++;
      if (bus.quotient !== eq || bus.remainder !== er || bus.dz !== 1'b0) begin
         n_fails++;
         $display("FAIL basic_result: q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=0",
                  bus.quotient, bus.remainder, bus.dz, eq, er);
      end
      for (int k = 0; k < 20; k++) begin
         idle_cycles(1);
         n_checks++;
         if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.quotient !== 8'd28 || bus.remainder !== 4'd4) begin
            n_fails++;
            $display("FAIL basic_hold_c%0d: done=%b busy=%b q=%0d r=%0d, want done=1 busy=0 q=28 r=4",
                     k, bus.done, bus.busy, bus.quotient, bus.remainder);
         end
      end
   endtask

   task automatic test_back_to_back();
      int c;
      drive_op(8'd255, 4'd15);
      wait_done(20, c);
      n_checks++;
      if (c != N || bus.quotient !== 8'd17 || bus.remainder !== 4'd0) begin
         n_fails++;
         $display("FAIL b2b_first: lat=%0d q=%0d r=%0d, want lat=%0d q=17 r=0",
                  c, bus.quotient, bus.remainder, N);
      end
      // The start is driven in the same cycle that done is high.
      drive_op(8'd13, 4'd14);
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.quotient !== 8'd17) begin
         n_fails++;
         $display("FAIL b2b_capture: done=%b busy=%b q=%0d, want done=0 busy=1 q=17 held",
                  bus.done, bus.busy, bus.quotient);
      end
      wait_done(20, c);
      n_checks++;
      if (c != N || bus.quotient !== 8'd0 || bus.remainder !== 4'd13) begin
         n_fails++;
         $display("FAIL b2b_second: lat=%0d q=%0d r=%0d, want lat=%0d q=0 r=13",
                  c, bus.quotient, bus.remainder, N);
      end
   endtask

   task automatic test_restart_ignored();
      drive_op(8'd255, 4'd1);
      for (int k = 1; k <= N; k++) begin
         if (k == 2 || k == 5) begin
            bus.start    = 1'b1;
            bus.dividend = 8'd9;
            bus.divisor  = 4'd3;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (k < N) begin
            n_checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
               n_fails++;
               $display("FAIL restart_run_c%0d: busy=%b done=%b, want busy=1 done=0",
                        k, bus.busy, bus.done);
            end
         end
      end
      bus.start = 1'b0;
      n_checks++;
      if (bus.done !== 1'b1 || bus.quotient !== 8'd255 || bus.remainder !== 4'd0) begin
         n_fails++;
         $display("FAIL restart_result: done=%b q=%0d r=%0d, want done=1 q=255 r=0",
                  bus.done, bus.quotient, bus.remainder);
      end
      idle_cycles(2);
      n_checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.quotient !== 8'd255) begin
         n_fails++;
         $display("FAIL restart_hold: done=%b busy=%b q=%0d, want done=1 busy=0 q=255",
                  bus.done, bus.busy, bus.quotient);
      end
   endtask

   task automatic test_div_zero();
      int c;
      logic [N-1:0] eq;
      logic [M-1:0] er;
      ref_div(8'hB6, 4'd0, eq, er);
      drive_op(8'hB6, 4'd0);
      wait_done(20, c);
      n_checks++;
      if (c != ZERO_LAT) begin
         n_fails++;
         $display("FAIL dz_latency: got %0d cycles, want %0d", c, ZERO_LAT);
      end
      n_checks++;
      if (bus.quotient !== eq || bus.remainder !== er || bus.dz !== ZERO_DZ) begin
         n_fails++;
         $display("FAIL dz_result: q=%0h r=%0h dz=%b, want q=%0h r=%0h dz=%b",
                  bus.quotient, bus.remainder, bus.dz, eq, er, ZERO_DZ);
      end
      // The next accepted start clears dz.
      drive_op(8'd10, 4'd3);
      n_checks++;
      if (bus.dz !== 1'b0) begin
         n_fails++;
         $display("FAIL dz_clear: dz=%b, want 0", bus.dz);
      end
      wait_done(20, c);
      n_checks++;
      if (c != N || bus.quotient !== 8'd3 || bus.remainder !== 4'd1 || bus.dz !== 1'b0) begin
         n_fails++;
         $display("FAIL dz_next: lat=%0d q=%0d r=%0d dz=%b, want lat=%0d q=3 r=1 dz=0",
                  c, bus.quotient, bus.remainder, bus.dz, N);
      end
   endtask

   task automatic test_reset_mid_op();
      int c;
      int seen_done;
      drive_op(8'd100, 4'd9);
      idle_cycles(3);
      #3;
      rst_b = 1'b0;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.dz, bus.quotient, bus.remainder} !== '0) begin
         n_fails++;
         $display("FAIL midrst_outputs: busy=%b done=%b dz=%b q=%0d r=%0d, want all 0",
                  bus.busy, bus.done, bus.dz, bus.quotient, bus.remainder);
      end
      @(posedge clk);
      #1;
      rst_b = 1'b1;
      seen_done = 0;
      for (int k = 0; k < 12; k++) begin
         idle_cycles(1);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done++;
      end
      n_checks++;
      if (seen_done != 0) begin
         n_fails++;
         $display("FAIL midrst_quiet: %0d cycles with busy/done set, want 0", seen_done);
      end
      drive_op(8'd100, 4'd9);
      wait_done(20, c);
      n_checks++;
      if (c != N || bus.quotient !== 8'd11 || bus.remainder !== 4'd1) begin
         n_fails++;
         $display("FAIL midrst_rerun: lat=%0d q=%0d r=%0d, want lat=%0d q=11 r=1",
                  c, bus.quotient, bus.remainder, N);
      end
   endtask

   task automatic test_random_sweep();
      logic [N+M-1:0] pairs[$];
      logic [N+M-1:0] tmp;
      logic [N+M-1:0] e;
      logic [N-1:0]   a, eq;
      logic [M-1:0]   b, er;
      int             c, j;
      for (int x = 0; x < (1 << N); x++)
         for (int y = 1; y < (1 << M); y++)
            pairs.push_back({N'(x), M'(y)});
      // Shuffle the pairs so the operands arrive in random order.
      for (int i = pairs.size() - 1; i > 0; i--) begin
         j = $urandom_range(i, 0);
         tmp      = pairs[i];
         pairs[i] = pairs[j];
         pairs[j] = tmp;
      end
      foreach (pairs[i]) begin
         a = pairs[i][N+M-1:M];
         b = pairs[i][M-1:0];
         ref_div(a, b, eq, er);
         exp_q.push_back({eq, er});
         if ($urandom_range(3, 0) == 0) idle_cycles($urandom_range(2, 1));
         drive_op(a, b);
         wait_done(20, c);
         e = exp_q.pop_front();
         n_checks++;
         if (c != N) begin
            n_fails++;
            $display("FAIL sweep_lat %0d/%0d: got %0d, want %0d", a, b, c, N);
         end
         n_checks++;
         if ({bus.quotient, bus.remainder} !== e) begin
            n_fails++;
            $display("FAIL sweep_val %0d/%0d: q=%0d r=%0d, want q=%0d r=%0d",
                     a, b, bus.quotient, bus.remainder, e[N+M-1:M], e[M-1:0]);
         end
         n_checks++;
         if (int'(bus.quotient) * int'(b) + int'(bus.remainder) != int'(a) ||
             int'(bus.remainder) >= int'(b)) begin
            n_fails++;
            $display("FAIL sweep_identity %0d/%0d: q=%0d r=%0d, want q*d+r=dividend and r<d",
                     a, b, bus.quotient, bus.remainder);
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_restart_ignored();
      test_div_zero();
      test_reset_mid_op();
      test_random_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
